// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle for the multi-cycle ALU.
// The slave modport is the ALU side; the master modport is the requester side.
interface alu_mc_if #(
  parameter int NUMBITS = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] A;
  logic [NUMBITS-1:0] B;
  logic [3:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
  logic               overflow;
  logic               zero;
  logic               illegal;

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero, illegal
  );

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts and a shift-add multiplier.
// Latency L means out_valid is high in the L-th cycle after the accepting edge.
module alu_mc #(
  parameter int NUMBITS = 32,
  parameter int SHW     = $clog2(NUMBITS)
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);

  localparam int MSB = NUMBITS - 1;
  localparam int W2  = 2 * NUMBITS;

  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUBU = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [MSB:0]     mcand_q, mcand_d;
  logic [W2-1:0]    work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [MSB:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [SHW-1:0]   sh;
  logic [NUMBITS:0] add_w;
  logic [NUMBITS:0] sub_w;
  logic [MSB:0]     step_sh;
  logic [W2-1:0]    step_mul;
  logic             fin;
  logic [MSB:0]     fin_res;
  logic             fin_carry;
  logic             fin_ovf;
  logic             fin_ill;

  function automatic logic [MSB:0] shift_step(input logic [3:0] op, input logic [MSB:0] x);
    case (op)
      OP_SLL:  return {x[MSB-1:0], 1'b0};
      OP_SRA:  return {x[MSB], x[MSB:1]};
      default: return {1'b0, x[MSB:1]};
    endcase
  endfunction

  // One shift-add step: {hi, lo} holds the partial product high half and the
  // not-yet-consumed multiplier bits; after NUMBITS steps it is the full product.
  function automatic logic [W2-1:0] mul_step(input logic [MSB:0] m, input logic [W2-1:0] p);
    logic [NUMBITS:0] s;
    s = {1'b0, p[W2-1:NUMBITS]} + (p[0] ? {1'b0, m} : {(NUMBITS+1){1'b0}});
    return {s, p[MSB:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mcand_d     = mcand_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    fin         = 1'b0;
    fin_res     = '0;
    fin_carry   = 1'b0;
    fin_ovf     = 1'b0;
    fin_ill     = 1'b0;
    step_sh     = '0;
    step_mul    = '0;
    sh          = bus.B[SHW-1:0];
    add_w       = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w       = {1'b0, bus.A} - {1'b0, bus.B};
    accept      = in_ready_q && bus.in_valid;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.opcode;
          mcand_d = bus.A;
          case (bus.opcode)
            OP_SRL, OP_SLL, OP_SRA: begin
              // The first bit is shifted on the accepting edge itself.
              step_sh = shift_step(bus.opcode, bus.A);
              if (sh == '0) begin
                fin     = 1'b1;
                fin_res = bus.A;
              end else if (sh == SHW'(1)) begin
                fin     = 1'b1;
                fin_res = step_sh;
              end else begin
                work_d  = {{NUMBITS{1'b0}}, step_sh};
                cnt_d   = sh - SHW'(1);
                state_d = BUSY;
              end
            end
            OP_MUL: begin
              work_d  = mul_step(bus.A, {{NUMBITS{1'b0}}, bus.B});
              cnt_d   = SHW'(NUMBITS - 1);
              state_d = BUSY;
            end
            default: begin
              fin = 1'b1;
              case (bus.opcode)
                OP_ADDU: begin
                  fin_res   = add_w[MSB:0];
                  fin_carry = add_w[NUMBITS];
                end
                OP_ADD: begin
                  fin_res = add_w[MSB:0];
                  fin_ovf = (bus.A[MSB] == bus.B[MSB]) && (add_w[MSB] != bus.A[MSB]);
                end
                OP_SUBU: begin
                  fin_res   = sub_w[MSB:0];
                  fin_carry = sub_w[NUMBITS];
                end
                OP_SUB: begin
                  fin_res = sub_w[MSB:0];
                  fin_ovf = (bus.A[MSB] != bus.B[MSB]) && (sub_w[MSB] != bus.A[MSB]);
                end
                OP_AND:  fin_res = bus.A & bus.B;
                OP_OR:   fin_res = bus.A | bus.B;
                OP_XOR:  fin_res = bus.A ^ bus.B;
                OP_NOR:  fin_res = ~(bus.A | bus.B);
                OP_SLT:  fin_res = {{MSB{1'b0}}, ($signed(bus.A) < $signed(bus.B))};
                OP_SLTU: fin_res = {{MSB{1'b0}}, sub_w[NUMBITS]};
                default: fin_ill = 1'b1;
              endcase
            end
          endcase
        end
      end
      BUSY: begin
        if (op_q == OP_MUL) begin
          step_mul = mul_step(mcand_q, work_q);
          work_d   = step_mul;
        end else begin
          step_sh = shift_step(op_q, work_q[MSB:0]);
          work_d  = {{NUMBITS{1'b0}}, step_sh};
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          fin       = 1'b1;
          fin_res   = (op_q == OP_MUL) ? step_mul[MSB:0] : step_sh;
          fin_carry = (op_q == OP_MUL) && (step_mul[W2-1:NUMBITS] != '0);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result and flags only change when an op completes; they hold otherwise.
    if (fin) begin
      state_d   = DONE;
      result_d  = fin_res;
      carry_d   = fin_carry;
      ovf_d     = fin_ovf;
      zero_d    = (fin_res == '0);
      illegal_d = fin_ill;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      mcand_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carryout  = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (NUMBITS=32) against an arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_mc;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  alu_mc_if #(.NUMBITS(32)) bus ();

  alu_mc #(.NUMBITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference: flags packed as {carryout, overflow, zero, illegal}.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    longint unsigned full;
    longint          s;
    logic            c, v, ill;
    logic [4:0]      sh;
    sh   = b[4:0];
    c    = 1'b0;
    v    = 1'b0;
    ill  = 1'b0;
    lat  = 1;
    r    = '0;
    full = 0;
    case (op)
      4'd0: begin full = longint'(a) + longint'(b); r = full[31:0]; c = full[32]; end
      4'd1: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = s[31:0];
        v = (s != longint'($signed(r)));
      end
      4'd2: begin r = a - b; c = (a < b); end
      4'd3: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        v = (s != longint'($signed(r)));
      end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  begin r = a >> sh; lat = (sh == 0) ? 1 : int'(sh); end
      4'd8:  begin r = a << sh; lat = (sh == 0) ? 1 : int'(sh); end
      4'd9:  begin r = 32'($signed(a) >>> sh); lat = (sh == 0) ? 1 : int'(sh); end
      4'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: r = (a < b) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      4'd13: begin full = longint'(a) * longint'(b); r = full[31:0]; c = (full[63:32] != 0); lat = 32; end
      default: ill = 1'b1;
    endcase
    f = {c, v, (r == 32'd0), ill};
  endtask

  task automatic scramble();
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.opcode   = 4'($urandom_range(0, 15));
    bus.in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic [3:0]  ef;
    int          el;
    int          cyc;
    int          lat;
    model(op, a, b, er, ef, el);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("ready_wait", 64'(bus.in_ready), 64'd1);
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    scramble();
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      scramble();
    end
    chk("latency", 64'(lat), 64'(el));
    chk("result", 64'(bus.result), 64'(er));
    chk("flags", 64'({bus.carryout, bus.overflow, bus.zero, bus.illegal}), 64'(ef));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
      chk("hold", 64'({bus.out_valid, bus.in_ready, bus.result,
                       bus.carryout, bus.overflow, bus.zero, bus.illegal}),
                  64'({1'b1, 1'b0, er, ef}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain", 64'({bus.out_valid, bus.in_ready, bus.result}), 64'({1'b0, 1'b1, er}));
    $display("op=%0d A=%h B=%h -> result=%h cvzi=%b latency=%0d hold=%0d",
             op, a, b, er, ef, lat, hold);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic saw_valid;
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({bus.in_ready, bus.out_valid, bus.result,
                            bus.carryout, bus.overflow, bus.zero, bus.illegal}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Directed boundary cases
    run_op(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd1,  32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd3,  32'h8000_0000, 32'h0000_0001, 0);
    run_op(4'd2,  32'h0000_0001, 32'h0000_0002, 0);
    run_op(4'd9,  32'h8000_0000, 32'h0000_0004, 0);
    run_op(4'd8,  32'h1234_5678, 32'h0000_0000, 0);
    run_op(4'd7,  32'hF000_000F, 32'h0000_001F, 0);
    run_op(4'd13, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(4'd13, 32'h0000_0003, 32'h0000_0005, 0);
    run_op(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op(4'd14, 32'h0000_0000, 32'h0000_0000, 0);
    run_op(4'd1,  32'h0000_0003, 32'h0000_0005, 10);

    // Reset in the middle of a multiply aborts it
    bus.opcode   = 4'd13;
    bus.A        = 32'h0000_0003;
    bus.B        = 32'h0000_0005;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({bus.in_ready, bus.out_valid, bus.result,
                              bus.carryout, bus.overflow, bus.zero, bus.illegal}), 64'd0);
    reset = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("abort_no_valid", 64'(saw_valid), 64'd0);
    chk("abort_ready", 64'(bus.in_ready), 64'd1);

    // Randomized operations
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
